// File: rtl/blake2_msg_feeder.sv
// blake2_msg_feeder: slices one keyed/unkeyed job into zero-padded 64-byte
// blocks for the blake2 core, then re-emits the nn-byte digest stream.
module blake2_msg_feeder #(
  parameter int LL_W = 64,
  parameter int KK_W = 6
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            cfg_v_i,
  output logic            cfg_ready_o,
  input  logic [KK_W-1:0] cfg_kk_i,
  input  logic [KK_W-1:0] cfg_nn_i,
  input  logic [LL_W-1:0] cfg_ll_i,
  input  logic            s_v_i,
  input  logic [7:0]      s_data_i,
  output logic            s_ready_o,
  output logic [KK_W-1:0] core_kk_o,
  output logic [KK_W-1:0] core_nn_o,
  output logic [127:0]    core_ll_o,
  output logic            core_block_first_o,
  output logic            core_block_last_o,
  output logic            core_data_v_o,
  output logic [5:0]      core_data_idx_o,
  output logic [7:0]      core_data_o,
  input  logic            core_ready_v_i,
  input  logic            core_h_v_i,
  input  logic [7:0]      core_h_i,
  output logic            res_v_o,
  output logic [7:0]      res_data_o,
  output logic            res_last_o
);
  // block count needs ceil(ll/64) plus one key block
  localparam int BW = LL_W - 4;

  typedef enum logic [1:0] {IDLE, FEED, WAIT_H, OUT} state_t;

  state_t          state, state_nx;
  logic [KK_W-1:0] kk_r, nn_r, out_cnt;
  logic [127:0]    ll_tot;
  logic [LL_W-1:0] msg_left;
  logic [BW-1:0]   blocks_left, cfg_blocks;
  logic            first_flag;
  logic [5:0]      byte_idx;
  logic            key_ph, strm_slot, last_blk, h_take;

  assign cfg_blocks = BW'(cfg_ll_i[LL_W-1:6]) + BW'(|cfg_ll_i[5:0]) + BW'(cfg_kk_i != '0);
  // key block: only the first kk slots come from the stream
  assign key_ph     = first_flag & (kk_r != '0);
  assign strm_slot  = key_ph ? (32'(byte_idx) < 32'(kk_r)) : (msg_left != '0);
  assign last_blk   = (blocks_left == BW'(1));
  assign h_take     = (state == OUT) & core_h_v_i;

  assign core_kk_o          = kk_r;
  assign core_nn_o          = nn_r;
  assign core_ll_o          = ll_tot;
  assign core_block_first_o = (state == FEED) & first_flag;
  assign core_block_last_o  = (state == FEED) & last_blk;
  assign core_data_idx_o    = (state == FEED) ? byte_idx : 6'd0;

  // state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  // next state and byte-slot handshakes
  always_comb begin
    state_nx      = state;
    cfg_ready_o   = 1'b0;
    s_ready_o     = 1'b0;
    core_data_v_o = 1'b0;
    core_data_o   = 8'd0;
    case (state)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_v_i) state_nx = FEED;
      end
      FEED: begin
        if (strm_slot) begin
          s_ready_o     = core_ready_v_i;
          core_data_v_o = s_v_i & core_ready_v_i;
          core_data_o   = s_data_i;
        end else begin
          core_data_v_o = core_ready_v_i;
        end
        if (core_data_v_o && byte_idx == 6'd63 && last_blk) state_nx = WAIT_H;
      end
      // core announces the digest one cycle early; that cycle is dropped
      WAIT_H: if (core_h_v_i) state_nx = OUT;
      OUT:    if (core_h_v_i && out_cnt == nn_r - KK_W'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // job config, block/byte counters and digest counter
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      kk_r        <= '0;
      nn_r        <= '0;
      ll_tot      <= '0;
      msg_left    <= '0;
      blocks_left <= '0;
      first_flag  <= 1'b0;
      byte_idx    <= '0;
      out_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_v_i) begin
          kk_r        <= cfg_kk_i;
          nn_r        <= cfg_nn_i;
          ll_tot      <= {{(128-LL_W){1'b0}}, cfg_ll_i} + ((cfg_kk_i != '0) ? 128'd64 : 128'd0);
          msg_left    <= cfg_ll_i;
          blocks_left <= (cfg_blocks == '0) ? BW'(1) : cfg_blocks;
          first_flag  <= 1'b1;
          byte_idx    <= '0;
        end
        FEED: if (core_data_v_o) begin
          byte_idx <= byte_idx + 6'd1;
          if (strm_slot && !key_ph) msg_left <= msg_left - LL_W'(1);
          if (byte_idx == 6'd63) begin
            first_flag  <= 1'b0;
            blocks_left <= blocks_left - BW'(1);
          end
        end
        WAIT_H: if (core_h_v_i) out_cnt <= '0;
        OUT:    if (core_h_v_i) out_cnt <= out_cnt + KK_W'(1);
        default: ;
      endcase
    end
  end

  // digest byte output, one cycle behind the core
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      res_v_o    <= 1'b0;
      res_data_o <= 8'd0;
      res_last_o <= 1'b0;
    end else begin
      res_v_o    <= h_take;
      res_data_o <= h_take ? core_h_i : 8'd0;
      res_last_o <= h_take & (out_cnt == nn_r - KK_W'(1));
    end
  end
endmodule
